// File: rtl/pwm_led_device.sv
// Bus-mapped LED controller: each output is a direct on/off bit or a PWM
// brightness channel, optionally gated by a global blink phase.
module pwm_led_device #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 16
) (
  input  logic                clk,
  input  logic                reset_n_i,
  input  logic                sel_i,
  input  logic                wr_en_i,
  input  logic [11:0]         address_in_i,
  input  logic [31:0]         data_in_i,
  output logic [31:0]         data_out_o,
  output logic                ack_o,
  output logic [NUM_LEDS-1:0] led_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_PWM_EN = 12'h001;
  localparam logic [11:0] ADDR_BLK_EN = 12'h002;
  localparam logic [11:0] ADDR_PERIOD = 12'h003;
  localparam logic [11:0] ADDR_STATUS = 12'h004;
  localparam logic [11:0] DUTY_BASE   = 12'h010;

  logic [NUM_LEDS-1:0] ctrl_q, ctrl_d;
  logic [NUM_LEDS-1:0] pwm_en_q, pwm_en_d;
  logic [NUM_LEDS-1:0] blink_en_q, blink_en_d;
  logic [15:0]         blink_period_q, blink_period_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_d [NUM_LEDS];

  logic [PS_W-1:0]     prescale_q, prescale_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;

  logic        wr_acc, rd_acc, period_wr;
  logic        tick, pwm_wrap;
  logic [31:0] rdata_mux;
  logic        unused_data;

  // Write data bits beyond the widest field are intentionally dropped.
  assign unused_data = ^data_in_i;

  assign wr_acc    = sel_i & wr_en_i;
  assign rd_acc    = sel_i & ~wr_en_i;
  assign period_wr = wr_acc && (address_in_i == ADDR_PERIOD);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_q         <= '0;
      pwm_en_q       <= '0;
      blink_en_q     <= '0;
      blink_period_q <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
      prescale_q     <= '0;
      pwm_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b1;
      led_q          <= '0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
    end else begin
      ctrl_q         <= ctrl_d;
      pwm_en_q       <= pwm_en_d;
      blink_en_q     <= blink_en_d;
      blink_period_q <= blink_period_d;
      duty_q         <= duty_d;
      prescale_q     <= prescale_d;
      pwm_cnt_q      <= pwm_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      led_q          <= led_d;
      ack_q          <= ack_d;
      rdata_q        <= rdata_d;
    end
  end

  // Register writes: only the defined field widths are stored.
  always_comb begin
    ctrl_d         = ctrl_q;
    pwm_en_d       = pwm_en_q;
    blink_en_d     = blink_en_q;
    blink_period_d = blink_period_q;
    duty_d         = duty_q;
    if (wr_acc) begin
      case (address_in_i)
        ADDR_CTRL:   ctrl_d         = data_in_i[NUM_LEDS-1:0];
        ADDR_PWM_EN: pwm_en_d       = data_in_i[NUM_LEDS-1:0];
        ADDR_BLK_EN: blink_en_d     = data_in_i[NUM_LEDS-1:0];
        ADDR_PERIOD: blink_period_d = data_in_i[15:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (address_in_i == DUTY_BASE + 12'(i)) duty_d[i] = data_in_i[PWM_BITS-1:0];
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (address_in_i)
      ADDR_CTRL:   rdata_mux[NUM_LEDS-1:0] = ctrl_q;
      ADDR_PWM_EN: rdata_mux[NUM_LEDS-1:0] = pwm_en_q;
      ADDR_BLK_EN: rdata_mux[NUM_LEDS-1:0] = blink_en_q;
      ADDR_PERIOD: rdata_mux[15:0]         = blink_period_q;
      ADDR_STATUS: rdata_mux = {15'd0, blink_phase_q, 16'(pwm_cnt_q)};
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (address_in_i == DUTY_BASE + 12'(i)) rdata_mux[PWM_BITS-1:0] = duty_q[i];
        end
      end
    endcase
  end

  // Data bus only carries a value in a read-ack cycle.
  always_comb begin
    ack_d   = sel_i;
    rdata_d = rd_acc ? rdata_mux : 32'd0;
  end

  always_comb begin
    tick       = (prescale_q == PS_MAX);
    pwm_wrap   = tick && (pwm_cnt_q == CNT_MAX);
    prescale_d = tick ? '0 : prescale_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
  end

  // A BLINK_PERIOD write restarts the blink sequence ahead of any wrap.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (period_wr || (blink_period_q == 16'd0)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (pwm_wrap) begin
      if (blink_cnt_q == blink_period_q - 16'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = (pwm_en_q[i] ? (pwm_cnt_q < duty_q[i]) : ctrl_q[i])
                 & (~blink_en_q[i] | blink_phase_q);
    end
  end

  assign data_out_o = rdata_q;
  assign ack_o      = ack_q;
  assign led_o      = led_q;

endmodule

// File: tb/tb_pwm_led_device.sv
// Bench for pwm_led_device: two instances (PRESCALE 1 and 3) share one bus and
// are compared every cycle against an arithmetic model of the time base.
module tb_pwm_led_device;

  localparam int PSA = 1;
  localparam int PSB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b;
  logic [7:0]  led_a, led_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pwm_led_device #(.NUM_LEDS(8), .PWM_BITS(4), .PRESCALE(PSA)) dut_a (
    .clk(clk), .reset_n_i(rst_n), .sel_i(sel), .wr_en_i(we),
    .address_in_i(addr), .data_in_i(din), .data_out_o(dout_a),
    .ack_o(ack_a), .led_o(led_a));

  pwm_led_device #(.NUM_LEDS(8), .PWM_BITS(4), .PRESCALE(PSB)) dut_b (
    .clk(clk), .reset_n_i(rst_n), .sel_i(sel), .wr_en_i(we),
    .address_in_i(addr), .data_in_i(din), .data_out_o(dout_b),
    .ack_o(ack_b), .led_o(led_b));

  // Model: register contents plus elapsed edge count; counters are derived.
  logic [7:0]  m_ctrl, m_pen, m_ben;
  logic [15:0] m_per;
  logic [3:0]  m_duty [8];
  int          n, wr_base;
  logic        exp_ack;
  logic [31:0] exp_rd_a, exp_rd_b;
  logic [7:0]  exp_led_a, exp_led_b;

  function automatic int pwm_of(input int ps, input int t);
    return (t / ps) % 16;
  endfunction

  function automatic logic phase_of(input int ps, input int t);
    int wraps;
    if (m_per == 16'd0) return 1'b1;
    wraps = t / (16 * ps) - wr_base / (16 * ps);
    return ((wraps / int'(m_per)) % 2) == 0;
  endfunction

  function automatic logic [31:0] rd_of(input int ps, input logic [11:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 12'h000) r = {24'd0, m_ctrl};
    else if (a == 12'h001) r = {24'd0, m_pen};
    else if (a == 12'h002) r = {24'd0, m_ben};
    else if (a == 12'h003) r = {16'd0, m_per};
    else if (a == 12'h004) r = (phase_of(ps, n) ? 32'h0001_0000 : 32'd0) + 32'(pwm_of(ps, n));
    else if (a >= 12'h010 && a < 12'h018) r = {28'd0, m_duty[a[2:0]]};
    return r;
  endfunction

  function automatic logic [7:0] led_of(input int ps);
    logic [7:0] r;
    logic base;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      base = m_pen[i] ? (pwm_of(ps, n) < int'(m_duty[i])) : m_ctrl[i];
      r[i] = base & (!m_ben[i] | phase_of(ps, n));
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctrl <= '0; m_pen <= '0; m_ben <= '0; m_per <= '0;
      for (int i = 0; i < 8; i++) m_duty[i] <= '0;
      n <= 0; wr_base <= 0;
      exp_ack <= 1'b0; exp_rd_a <= '0; exp_rd_b <= '0;
      exp_led_a <= '0; exp_led_b <= '0;
    end else begin
      exp_ack   <= sel;
      exp_rd_a  <= (sel && !we) ? rd_of(PSA, addr) : 32'd0;
      exp_rd_b  <= (sel && !we) ? rd_of(PSB, addr) : 32'd0;
      exp_led_a <= led_of(PSA);
      exp_led_b <= led_of(PSB);
      n <= n + 1;
      if (sel && we) begin
        if (addr == 12'h000) m_ctrl <= din[7:0];
        else if (addr == 12'h001) m_pen <= din[7:0];
        else if (addr == 12'h002) m_ben <= din[7:0];
        else if (addr == 12'h003) begin
          m_per   <= din[15:0];
          wr_base <= n + 1;
        end else if (addr >= 12'h010 && addr < 12'h018) m_duty[addr[2:0]] <= din[3:0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ack_a", {31'd0, ack_a}, {31'd0, exp_ack});
    chk("ack_b", {31'd0, ack_b}, {31'd0, exp_ack});
    chk("data_a", dout_a, exp_rd_a);
    chk("data_b", dout_b, exp_rd_b);
    chk("led_a", {24'd0, led_a}, {24'd0, exp_led_a});
    chk("led_b", {24'd0, led_b}, {24'd0, exp_led_b});
  end

  // Called at a falling edge; returns in the ack cycle with the read data.
  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] ra, output logic [31:0] rb);
    sel = 1'b1; we = w; addr = a; din = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
    chk("bus_ack", {31'd0, ack_a}, 32'd1);
    ra = dout_a; rb = dout_b;
  endtask

  task automatic count_on(input int cycles, input int bit_i, output int ca, output int cb);
    ca = 0; cb = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      ca += int'(led_a[bit_i]);
      cb += int'(led_b[bit_i]);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int ca, cb;
    logic [31:0] duties [3];
    duties[0] = 32'd5; duties[1] = 32'd0; duties[2] = 32'd15;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 12'h004, 32'd0, ra, rb);
    chk("status_rst_a", ra, 32'h0001_0000);
    chk("status_rst_b", rb, 32'h0001_0000);
    for (int a = 0; a < 4; a++) begin
      bus(1'b0, 12'(a), 32'd0, ra, rb);
      chk("reg_rst", ra, 32'd0);
    end

    bus(1'b1, 12'h000, 32'hFFFF_FFA5, ra, rb);
    chk("wr_ack_data", ra, 32'd0);
    @(negedge clk);
    chk("led_ctrl", {24'd0, led_a}, 32'h0000_00A5);
    bus(1'b0, 12'h000, 32'd0, ra, rb);
    chk("ctrl_rb", ra, 32'h0000_00A5);
    bus(1'b0, 12'h7FF, 32'd0, ra, rb);
    chk("unmapped_rd", ra, 32'd0);

    bus(1'b1, 12'h001, 32'h0000_0001, ra, rb);
    for (int d = 0; d < 3; d++) begin
      bus(1'b1, 12'h010, duties[d], ra, rb);
      repeat (2) @(negedge clk);
      count_on(48, 0, ca, cb);
      chk("duty_on_a", 32'(ca), 3 * duties[d]);
      chk("duty_on_b", 32'(cb), 3 * duties[d]);
    end

    bus(1'b1, 12'h000, 32'h0000_0002, ra, rb);
    bus(1'b1, 12'h002, 32'h0000_0002, ra, rb);
    bus(1'b1, 12'h003, 32'h0000_0002, ra, rb);
    count_on(64, 1, ca, cb);
    chk("blink_a", 32'(ca), 32'd32);
    count_on(192, 1, ca, cb);
    chk("blink_b", 32'(cb), 32'd96);
    bus(1'b1, 12'h003, 32'h0000_0000, ra, rb);
    repeat (2) @(negedge clk);
    count_on(32, 1, ca, cb);
    chk("blink_off_a", 32'(ca), 32'd32);

    sel = 1'b1; we = 1'b0; addr = 12'h000;
    @(negedge clk); chk("burst0", dout_a, 32'h0000_0002); addr = 12'h001;
    @(negedge clk); chk("burst1", dout_a, 32'h0000_0001); addr = 12'h002;
    @(negedge clk); chk("burst2", dout_a, 32'h0000_0002); addr = 12'h010;
    @(negedge clk); chk("burst3", dout_a, 32'h0000_000F);
    we = 1'b1; addr = 12'h7FF; din = $urandom;
    @(negedge clk);
    chk("burst_wr_data", dout_a, 32'd0);
    chk("burst_wr_ack", {31'd0, ack_a}, 32'd1);
    sel = 1'b0; we = 1'b0;

    @(negedge clk);
    chk("led_before_rst", {31'd0, led_a[1]}, 32'd1);
    sel = 1'b1; addr = 12'h000;
    @(posedge clk);
    #2;
    chk("ack_pending", {31'd0, ack_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_led_a", {24'd0, led_a}, 32'd0);
    chk("async_ack_a", {31'd0, ack_a}, 32'd0);
    chk("async_led_b", {24'd0, led_b}, 32'd0);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, 12'h004, 32'd0, ra, rb);
    chk("status_rel_a", ra, 32'h0001_0000);
    chk("status_rel_b", rb, 32'h0001_0000);

    for (int k = 0; k < 1500; k++) begin
      sel = ($urandom_range(0, 9) < 7);
      we  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 5))
        0, 1:    addr = 12'($urandom_range(0, 4));
        2, 3:    addr = 12'(16 + $urandom_range(0, 8));
        4:       addr = 12'h7FF;
        default: addr = 12'($urandom);
      endcase
      din = (addr == 12'h003) ? ($urandom & 32'hFFFF_0003) : $urandom;
      @(negedge clk);
    end
    sel = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
